// File: rtl/sys_arr_pkg.sv
// Shared definitions for the sys_arr sequencing controller: op encodings,
// FSM state type and the array's WS pipeline latency.
package sys_arr_pkg;

  // Encoding bits are {os, os-drain, ws-load}
  localparam logic [2:0] WS_LOAD  = 3'b001;
  localparam logic [2:0] WS_FLOW  = 3'b000;
  localparam logic [2:0] OS_FLOW  = 3'b100;
  localparam logic [2:0] OS_DRAIN = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLOW,
    DRAIN,
    DONE
  } state_t;

  function automatic int pipe_lat(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth 1-bit shift register with async active-low reset and a
// synchronous flush; carries WS activation-read strobes to the result write.
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;
  logic [DEPTH-1:0] shift_in;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign shift_in[gi] = din;
      end else begin : g_rest
        assign shift_in[gi] = sr_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    sr_d = clr ? '0 : shift_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/sys_arr_ctrl.sv
// Load/flow/drain sequencer for the sys_arr systolic array with buffer strobes.
// Optional abort input is enabled by defining SYS_ARR_CTRL_ABORT_EN.
module sys_arr_ctrl
  import sys_arr_pkg::*;
#(
  parameter int SYS_ARR_SIZE = 8,
  parameter int OP_SIG_WIDTH = 3,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SYS_ARR_CTRL_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    start,
  input  logic                    mode,
  input  logic [LEN_WIDTH-1:0]    num_vec,
  output logic                    busy,
  output logic                    done,
  output logic [OP_SIG_WIDTH-1:0] operation_signal_out,
  output logic                    wgt_rd_en,
  output logic [LEN_WIDTH-1:0]    wgt_rd_addr,
  output logic                    act_rd_en,
  output logic [LEN_WIDTH-1:0]    act_rd_addr,
  output logic                    res_wr_en,
  output logic [LEN_WIDTH-1:0]    res_wr_addr
);

  localparam int N  = SYS_ARR_SIZE;
  localparam int PL = pipe_lat(SYS_ARR_SIZE);
  localparam int CW = LEN_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    k_q, k_d;
  logic                    mode_q, mode_d;
  logic [LEN_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [LEN_WIDTH-1:0]    res_cnt_q, res_cnt_d;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [OP_SIG_WIDTH-1:0] op_q, op_d;
  logic                    wgt_rd_en_q, wgt_rd_en_d;
  logic [LEN_WIDTH-1:0]    wgt_rd_addr_q, wgt_rd_addr_d;
  logic                    act_rd_en_q, act_rd_en_d;
  logic [LEN_WIDTH-1:0]    act_rd_addr_q, act_rd_addr_d;
  logic                    res_wr_en_q, res_wr_en_d;
  logic [LEN_WIDTH-1:0]    res_wr_addr_q, res_wr_addr_d;

  logic                    abort_w;
  logic                    abort_act;
  logic                    ws_wr_pend;
  logic [CW-1:0]           last_cnt;
  logic                    phase_entry;
  logic                    in_act;
  logic [LEN_WIDTH-1:0]    rd_base;
  logic [LEN_WIDTH-1:0]    res_base;

`ifdef SYS_ARR_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign abort_act = abort_w && (state_q != IDLE);

  // Read strobes reach the write side 2N cycles later, then one output register
  valid_delay #(.DEPTH(PL - 1)) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .clr   (abort_act),
    .din   (act_rd_en_q),
    .dout  (ws_wr_pend)
  );

  always_comb begin
    case (state_q)
      LOAD:    last_cnt = CW'(N - 1);
      FLOW:    last_cnt = mode_q ? ({1'b0, k_q} + CW'(2 * N - 1))
                                 : ({1'b0, k_q} + CW'(PL - 1));
      DRAIN:   last_cnt = CW'(N);
      default: last_cnt = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    k_d     = k_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort_w) begin
          k_d    = num_vec;
          mode_d = mode;
          if (num_vec == '0) begin
            state_d = DONE;
          end else if (mode) begin
            state_d = FLOW;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cnt_q == last_cnt) begin
          state_d = FLOW;
          cnt_d   = '0;
        end
      end
      FLOW: begin
        if (cnt_q == last_cnt) begin
          state_d = mode_q ? DRAIN : DONE;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == last_cnt) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_act) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from next-cycle state so every output is a flop
  always_comb begin
    phase_entry = (state_d != state_q);
    rd_base     = phase_entry ? '0 : rd_cnt_q;
    res_base    = phase_entry ? '0 : res_cnt_q;
    in_act      = (state_d == FLOW) && (cnt_d < {1'b0, k_d});

    wgt_rd_en_d   = (state_d == LOAD) || (in_act && mode_d);
    act_rd_en_d   = in_act;
    wgt_rd_addr_d = wgt_rd_en_d ? rd_base : '0;
    act_rd_addr_d = act_rd_en_d ? rd_base : '0;
    rd_cnt_d      = rd_base + LEN_WIDTH'(wgt_rd_en_d | act_rd_en_d);

    res_wr_en_d   = ((state_d == FLOW) && !mode_d && ws_wr_pend) ||
                    ((state_d == DRAIN) && (cnt_d != '0));
    res_wr_addr_d = res_wr_en_d ? res_base : '0;
    res_cnt_d     = res_base + LEN_WIDTH'(res_wr_en_d);

    case (state_d)
      LOAD:    op_d = OP_SIG_WIDTH'(WS_LOAD);
      FLOW:    op_d = mode_d ? OP_SIG_WIDTH'(OS_FLOW) : OP_SIG_WIDTH'(WS_FLOW);
      DRAIN:   op_d = OP_SIG_WIDTH'(OS_DRAIN);
      default: op_d = OP_SIG_WIDTH'(WS_FLOW);
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      k_q           <= '0;
      mode_q        <= 1'b0;
      rd_cnt_q      <= '0;
      res_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      op_q          <= '0;
      wgt_rd_en_q   <= 1'b0;
      wgt_rd_addr_q <= '0;
      act_rd_en_q   <= 1'b0;
      act_rd_addr_q <= '0;
      res_wr_en_q   <= 1'b0;
      res_wr_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      mode_q        <= mode_d;
      rd_cnt_q      <= rd_cnt_d;
      res_cnt_q     <= res_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      op_q          <= op_d;
      wgt_rd_en_q   <= wgt_rd_en_d;
      wgt_rd_addr_q <= wgt_rd_addr_d;
      act_rd_en_q   <= act_rd_en_d;
      act_rd_addr_q <= act_rd_addr_d;
      res_wr_en_q   <= res_wr_en_d;
      res_wr_addr_q <= res_wr_addr_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign operation_signal_out = op_q;
  assign wgt_rd_en            = wgt_rd_en_q;
  assign wgt_rd_addr          = wgt_rd_addr_q;
  assign act_rd_en            = act_rd_en_q;
  assign act_rd_addr          = act_rd_addr_q;
  assign res_wr_en            = res_wr_en_q;
  assign res_wr_addr          = res_wr_addr_q;

endmodule
